dsp_pipe_delay: RTL and testbench

- Parametrised successor of the single-stage register/bypass pair used on DSP48A1 operand paths.
- Provides a configurable-depth register pipeline (0 = pure bypass) with valid-bit tracking, flush, and an in-flight counter.
- Offers an optional last-valid hold on the output.
- Sits on operand and result paths (A, B, C, D, M, P) wherever latency must be tuned per build.

---
 rtl/dsp_pipe_delay.sv | 122 ++++++++++++
 tb/tb_dsp_pipe_delay.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_pipe_delay.sv
// Configurable-depth register pipeline with valid tracking, flush, in-flight count
// and optional last-valid hold. Define DSP_PIPE_DELAY_TAPS_EN to export per-stage taps.
module dsp_pipe_delay #(
   parameter int WIDTH     = 18,
   parameter int DEPTH     = 1,
   parameter int HOLD_LAST = 0,
   localparam int CW       = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CEN,
   input  logic             FLUSH,
   input  logic [WIDTH-1:0] A,
   input  logic             VLD_IN,
   output logic [WIDTH-1:0] C,
   output logic             VLD_OUT,
   output logic [CW-1:0]    COUNT,
   output logic             IDLE
`ifdef DSP_PIPE_DELAY_TAPS_EN
   ,
   output logic [((DEPTH < 1) ? 1 : WIDTH * DEPTH)-1:0] TAPS,
   output logic [((DEPTH < 1) ? 1 : DEPTH)-1:0]         TAP_VLD
`endif
);

   if (WIDTH < 1 || WIDTH > 64 || DEPTH < 0 || DEPTH > 8) begin : g_param_check
      $error("dsp_pipe_delay: illegal parameters WIDTH=%0d DEPTH=%0d", WIDTH, DEPTH);
   end

   if (DEPTH == 0) begin : g_bypass
      // Pure wire: control inputs are intentionally ignored.
      logic unused_ctrl;
      assign unused_ctrl = ^{CLK, RST, CEN, FLUSH};

      assign C       = A;
      assign VLD_OUT = VLD_IN;
      assign COUNT   = '0;
      assign IDLE    = 1'b1;
`ifdef DSP_PIPE_DELAY_TAPS_EN
      assign TAPS    = '0;
      assign TAP_VLD = '0;
`else
      // taps disabled: no register views exported
`endif
   end else begin : g_pipe
      logic [WIDTH-1:0] d_reg [DEPTH];
      logic [DEPTH-1:0] v_reg;
      logic [WIDTH-1:0] d_in  [DEPTH];
      logic [DEPTH-1:0] v_in;
      logic [CW-1:0]    count_next;

      // Stage k is fed by stage k-1; stage 0 is fed by the input port.
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_link
         if (gi == 0) begin : g_head
            assign d_in[gi] = A;
            assign v_in[gi] = VLD_IN;
         end else begin : g_body
            assign d_in[gi] = d_reg[gi-1];
            assign v_in[gi] = v_reg[gi-1];
         end
      end

      always_ff @(posedge CLK) begin
         if (RST) begin
            v_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
               d_reg[i] <= '0;
            end
         end else begin
            // Flush kills validity even when stalled; data still obeys CEN.
            if (FLUSH) begin
               v_reg <= '0;
            end else if (CEN) begin
               v_reg <= v_in;
            end
            if (CEN) begin
               for (int i = 0; i < DEPTH; i++) begin
                  d_reg[i] <= d_in[i];
               end
            end
         end
      end

      always_comb begin
         count_next = '0;
         for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + CW'(v_reg[i]);
         end
      end

      assign COUNT   = count_next;
      assign IDLE    = (count_next == '0);
      assign VLD_OUT = v_reg[DEPTH-1];

      if (HOLD_LAST != 0) begin : g_hold
         logic [WIDTH-1:0] hold_reg;

         // Captures the word currently leaving, so the hold adds no latency.
         always_ff @(posedge CLK) begin
            if (RST) begin
               hold_reg <= '0;
            end else if (CEN && v_reg[DEPTH-1]) begin
               hold_reg <= d_reg[DEPTH-1];
            end
         end

         assign C = v_reg[DEPTH-1] ? d_reg[DEPTH-1] : hold_reg;
      end else begin : g_raw
         assign C = d_reg[DEPTH-1];
      end

`ifdef DSP_PIPE_DELAY_TAPS_EN
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_taps
         assign TAPS[gi*WIDTH +: WIDTH] = d_reg[gi];
      end
      assign TAP_VLD = v_reg;
`else
      // taps disabled: no register views exported
`endif
   end

endmodule

// File: tb/tb_dsp_pipe_delay.sv
// Directed bench for dsp_pipe_delay across several DEPTH/HOLD_LAST builds sharing one stimulus bus.
module tb_dsp_pipe_delay;

   logic        clk;
   logic        rst;
   logic        cen;
   logic        flush;
   logic [17:0] a;
   logic        vld_in;

   logic [17:0] c3, c4, c2h, c2n, c0;
   logic        v3, v4, v2h, v2n, v0;
   logic [1:0]  n3, n2h, n2n;
   logic [2:0]  n4;
   logic [0:0]  n0;
   logic        i3, i4, i2h, i2n, i0;

`ifdef DSP_PIPE_DELAY_TAPS_EN
   logic [53:0] taps3;
   logic [2:0]  tv3;
   logic [71:0] taps4;
   logic [3:0]  tv4;
   logic [35:0] taps2h, taps2n;
   logic [1:0]  tv2h, tv2n;
   logic [0:0]  taps0, tv0;
`endif

   int n_vec = 0;
   int n_err = 0;

   dsp_pipe_delay #(.WIDTH(18), .DEPTH(3), .HOLD_LAST(0)) u3 (
      .CLK(clk), .RST(rst), .CEN(cen), .FLUSH(flush), .A(a), .VLD_IN(vld_in),
      .C(c3), .VLD_OUT(v3), .COUNT(n3), .IDLE(i3)
`ifdef DSP_PIPE_DELAY_TAPS_EN
      , .TAPS(taps3), .TAP_VLD(tv3)
`endif
   );

   dsp_pipe_delay #(.WIDTH(18), .DEPTH(4), .HOLD_LAST(0)) u4 (
      .CLK(clk), .RST(rst), .CEN(cen), .FLUSH(flush), .A(a), .VLD_IN(vld_in),
      .C(c4), .VLD_OUT(v4), .COUNT(n4), .IDLE(i4)
`ifdef DSP_PIPE_DELAY_TAPS_EN
      , .TAPS(taps4), .TAP_VLD(tv4)
`endif
   );

   dsp_pipe_delay #(.WIDTH(18), .DEPTH(2), .HOLD_LAST(1)) u2h (
      .CLK(clk), .RST(rst), .CEN(cen), .FLUSH(flush), .A(a), .VLD_IN(vld_in),
      .C(c2h), .VLD_OUT(v2h), .COUNT(n2h), .IDLE(i2h)
`ifdef DSP_PIPE_DELAY_TAPS_EN
      , .TAPS(taps2h), .TAP_VLD(tv2h)
`endif
   );

   dsp_pipe_delay #(.WIDTH(18), .DEPTH(2), .HOLD_LAST(0)) u2n (
      .CLK(clk), .RST(rst), .CEN(cen), .FLUSH(flush), .A(a), .VLD_IN(vld_in),
      .C(c2n), .VLD_OUT(v2n), .COUNT(n2n), .IDLE(i2n)
`ifdef DSP_PIPE_DELAY_TAPS_EN
      , .TAPS(taps2n), .TAP_VLD(tv2n)
`endif
   );

   dsp_pipe_delay #(.WIDTH(18), .DEPTH(0), .HOLD_LAST(1)) u0 (
      .CLK(clk), .RST(rst), .CEN(cen), .FLUSH(flush), .A(a), .VLD_IN(vld_in),
      .C(c0), .VLD_OUT(v0), .COUNT(n0), .IDLE(i0)
`ifdef DSP_PIPE_DELAY_TAPS_EN
      , .TAPS(taps0), .TAP_VLD(tv0)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; cen = 1'b0; flush = 1'b0; vld_in = 1'b0; a = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [21:0] exp3;
      logic [22:0] exp4;
      logic [21:0] exp2;
      do_reset();
      exp3 = {18'h0, 1'b0, 2'd0, 1'b1};
      exp4 = {18'h0, 1'b0, 3'd0, 1'b1};
      exp2 = {18'h0, 1'b0, 2'd0, 1'b1};
      n_vec++;
      if ({c3, v3, n3, i3} !== exp3) begin
         n_err++; $display("FAIL reset_d3 got=%h exp=%h", {c3, v3, n3, i3}, exp3);
      end
      n_vec++;
      if ({c4, v4, n4, i4} !== exp4) begin
         n_err++; $display("FAIL reset_d4 got=%h exp=%h", {c4, v4, n4, i4}, exp4);
      end
      n_vec++;
      if ({c2h, v2h, n2h, i2h} !== exp2) begin
         n_err++; $display("FAIL reset_d2h got=%h exp=%h", {c2h, v2h, n2h, i2h}, exp2);
      end
      $display("reset: C/VLD_OUT/COUNT/IDLE checked on depth 3, 4, 2");
   endtask

   task automatic test_stream();
      int exp_c [8];
      int exp_v [8];
      int exp_n [8];
      logic [21:0] exp;
      exp_c = '{0, 0, 1, 2, 3, 4, 5, 0};
      exp_v = '{0, 0, 1, 1, 1, 1, 1, 0};
      exp_n = '{1, 2, 3, 3, 3, 2, 1, 0};
      do_reset();
      cen = 1'b1;
      for (int e = 0; e < 8; e++) begin
         if (e < 5) begin
            a = 18'(e + 1); vld_in = 1'b1;
         end else begin
            a = '0; vld_in = 1'b0;
         end
         tick();
         exp = {18'(exp_c[e]), exp_v[e] != 0, 2'(exp_n[e]), exp_n[e] == 0};
         n_vec++;
         if ({c3, v3, n3, i3} !== exp) begin
            n_err++; $display("FAIL stream edge%0d got=%h exp=%h", e + 1, {c3, v3, n3, i3}, exp);
         end
         $display("stream edge %0d: C=%h VLD_OUT=%b COUNT=%0d", e + 1, c3, v3, n3);
      end
   endtask

   task automatic test_stall();
      logic [21:0] exp;
      do_reset();
      cen = 1'b1; a = 18'h2AAAA; vld_in = 1'b1;
      tick();
      a = '0; vld_in = 1'b0; cen = 1'b0;
      for (int s = 0; s < 4; s++) begin
         tick();
         exp = {18'h0, 1'b0, 2'd1, 1'b0};
         n_vec++;
         if ({c3, v3, n3, i3} !== exp) begin
            n_err++; $display("FAIL stall cyc%0d got=%h exp=%h", s, {c3, v3, n3, i3}, exp);
         end
         $display("stall cycle %0d: COUNT=%0d VLD_OUT=%b", s, n3, v3);
      end
      cen = 1'b1;
      tick();
      exp = {18'h0, 1'b0, 2'd1, 1'b0};
      n_vec++;
      if ({c3, v3, n3, i3} !== exp) begin
         n_err++; $display("FAIL stall_resume1 got=%h exp=%h", {c3, v3, n3, i3}, exp);
      end
      tick();
      exp = {18'h2AAAA, 1'b1, 2'd1, 1'b0};
      n_vec++;
      if ({c3, v3, n3, i3} !== exp) begin
         n_err++; $display("FAIL stall_emerge got=%h exp=%h", {c3, v3, n3, i3}, exp);
      end
      $display("stall emerge: C=%h VLD_OUT=%b", c3, v3);
      tick();
      exp = {18'h0, 1'b0, 2'd0, 1'b1};
      n_vec++;
      if ({c3, v3, n3, i3} !== exp) begin
         n_err++; $display("FAIL stall_drain got=%h exp=%h", {c3, v3, n3, i3}, exp);
      end
   endtask

   task automatic test_flush();
      logic [22:0] exp;
      do_reset();
      cen = 1'b1; vld_in = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a = 18'(17 * (k + 1));
         tick();
      end
      exp = {18'h11, 1'b1, 3'd4, 1'b0};
      n_vec++;
      if ({c4, v4, n4, i4} !== exp) begin
         n_err++; $display("FAIL flush_full got=%h exp=%h", {c4, v4, n4, i4}, exp);
      end
      $display("flush fill: COUNT=%0d C=%h", n4, c4);
      flush = 1'b1; vld_in = 1'b1; a = 18'h3FFFF;
      tick();
      flush = 1'b0; vld_in = 1'b0; a = '0;
      exp = {18'h22, 1'b0, 3'd0, 1'b1};
      n_vec++;
      if ({c4, v4, n4, i4} !== exp) begin
         n_err++; $display("FAIL flush_clear got=%h exp=%h", {c4, v4, n4, i4}, exp);
      end
      $display("flush applied: COUNT=%0d IDLE=%b VLD_OUT=%b", n4, i4, v4);
      for (int k = 0; k < 4; k++) begin
         tick();
         n_vec++;
         if ({v4, n4, i4} !== {1'b0, 3'd0, 1'b1}) begin
            n_err++; $display("FAIL flush_after%0d got=%b/%0d/%b exp=0/0/1", k, v4, n4, i4);
         end
      end
   endtask

   task automatic test_hold_last();
      do_reset();
      cen = 1'b1; a = 18'h00055; vld_in = 1'b1;
      tick();
      n_vec++;
      if ({c2h, v2h} !== {18'h0, 1'b0}) begin
         n_err++; $display("FAIL hold_e1 got=%h/%b exp=0/0", c2h, v2h);
      end
      a = 18'h00F0F; vld_in = 1'b0;
      tick();
      n_vec++;
      if ({c2h, v2h, c2n, v2n} !== {18'h55, 1'b1, 18'h55, 1'b1}) begin
         n_err++; $display("FAIL hold_e2 got=%h/%b %h/%b exp=55/1 55/1", c2h, v2h, c2n, v2n);
      end
      $display("hold edge 2: Chold=%h Craw=%h", c2h, c2n);
      for (int k = 0; k < 2; k++) begin
         tick();
         n_vec++;
         if ({c2h, v2h, c2n, v2n} !== {18'h55, 1'b0, 18'h00F0F, 1'b0}) begin
            n_err++; $display("FAIL hold_bubble%0d got=%h/%b %h/%b exp=55/0 f0f/0", k, c2h, v2h, c2n, v2n);
         end
         $display("hold bubble %0d: Chold=%h Craw=%h", k, c2h, c2n);
      end
   endtask

   task automatic test_reset_midstream();
      logic [21:0] exp;
      do_reset();
      cen = 1'b1; vld_in = 1'b1;
      a = 18'h101; tick();
      a = 18'h202; tick();
      n_vec++;
      if (n3 !== 2'd2) begin
         n_err++; $display("FAIL midrst_inflight got=%0d exp=2", n3);
      end
      cen = 1'b0; rst = 1'b1; a = 18'h3333;
      tick();
      rst = 1'b0;
      exp = {18'h0, 1'b0, 2'd0, 1'b1};
      n_vec++;
      if ({c3, v3, n3, i3} !== exp) begin
         n_err++; $display("FAIL midrst_clear got=%h exp=%h", {c3, v3, n3, i3}, exp);
      end
      cen = 1'b1; a = 18'h404; vld_in = 1'b1;
      tick();
      a = '0; vld_in = 1'b0;
      tick();
      n_vec++;
      if ({v3, n3} !== {1'b0, 2'd1}) begin
         n_err++; $display("FAIL midrst_early got=%b/%0d exp=0/1", v3, n3);
      end
      tick();
      exp = {18'h404, 1'b1, 2'd1, 1'b0};
      n_vec++;
      if ({c3, v3, n3, i3} !== exp) begin
         n_err++; $display("FAIL midrst_emerge got=%h exp=%h", {c3, v3, n3, i3}, exp);
      end
      $display("reset mid-stream: post-reset word C=%h VLD_OUT=%b", c3, v3);
   endtask

   task automatic test_bypass();
      for (int k = 0; k < 12; k++) begin
         a = 18'($urandom_range(0, 18'h3FFFF));
         vld_in = 1'($urandom_range(0, 1));
         rst = 1'($urandom_range(0, 1));
         flush = 1'($urandom_range(0, 1));
         cen = 1'($urandom_range(0, 1));
         #1;
         n_vec++;
         if ({c0, v0, n0, i0} !== {a, vld_in, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL bypass%0d got=%h/%b/%0d/%b exp=%h/%b/0/1", k, c0, v0, n0, i0, a, vld_in);
         end
         $display("bypass %0d: A=%h C=%h VLD_IN=%b VLD_OUT=%b", k, a, c0, vld_in, v0);
         tick();
      end
      rst = 1'b0; flush = 1'b0;
   endtask

   initial begin
      rst = 1'b0; cen = 1'b0; flush = 1'b0; a = '0; vld_in = 1'b0;
      #2;
      test_reset();
      test_stream();
      test_stall();
      test_flush();
      test_hold_last();
      test_reset_midstream();
      test_bypass();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
